rbe_tcdm_split: RTL and testbench

RBE_TCDM_SPLIT -- requirements
Module: rbe_tcdm_split

---
 rtl/rbe_tcdm_split.sv | 145 ++++++++++++++
 tb/tb_rbe_tcdm_split.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rbe_tcdm_split.sv
// Splits one wide upstream TCDM request into MP independent 32-bit lane requests
// and reassembles the per-lane read responses into a single wide response.
//
// state | meaning
// IDLE  | no transaction in flight; lane requests follow in_req_i
// ISSUE | some active lanes granted, waiting for the rest
// WAIT  | read fully granted, collecting lane responses
module rbe_tcdm_split #(
    parameter int unsigned BW            = 288,
    parameter int unsigned SKIP_EMPTY_WR = 1,
    localparam int unsigned MP           = BW / 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   in_req_i,
    output logic                   in_gnt_o,
    input  logic [31:0]            in_add_i,
    input  logic                   in_wen_i,
    input  logic [BW/8-1:0]        in_be_i,
    input  logic [BW-1:0]          in_data_i,
    output logic                   in_r_valid_o,
    output logic [BW-1:0]          in_r_data_o,
    output logic [MP-1:0]          tcdm_req_o,
    output logic [MP-1:0][31:0]    tcdm_add_o,
    output logic [MP-1:0]          tcdm_wen_o,
    output logic [MP-1:0][3:0]     tcdm_be_o,
    output logic [MP-1:0][31:0]    tcdm_data_o,
    input  logic [MP-1:0]          tcdm_gnt_i,
    input  logic [MP-1:0]          tcdm_r_valid_i,
    input  logic [MP-1:0][31:0]    tcdm_r_data_i,
    output logic [31:0]            stall_cnt_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state_q;
    logic [MP-1:0]        done_q;
    logic [MP-1:0]        exp_q;
    logic [MP-1:0][31:0]  buf_q;

    logic [MP-1:0]        write_mask;
    logic [MP-1:0]        active_mask;
    logic                 req_phase;
    logic [MP-1:0]        granted;
    logic [MP-1:0]        resp;
    logic [MP-1:0]        unexpected;
    logic                 last_resp;

    always_comb begin
        write_mask = '0;
        tcdm_add_o = '0;
        tcdm_be_o = '0;
        tcdm_data_o = '0;
        tcdm_wen_o = '0;
        for (int i = 0; i < int'(MP); i++) begin
            tcdm_add_o[i]  = in_add_i + 32'(4 * i);
            tcdm_be_o[i]   = in_be_i[4*i +: 4];
            tcdm_data_o[i] = in_data_i[32*i +: 32];
            tcdm_wen_o[i]  = in_wen_i;
            write_mask[i]  = |in_be_i[4*i +: 4];
        end

        // Reads always touch every lane; empty write lanes may be dropped.
        if (in_wen_i || SKIP_EMPTY_WR == 0) begin
            active_mask = '1;
        end else begin
            active_mask = write_mask;
        end

        req_phase  = in_req_i && (state_q != WAIT);
        tcdm_req_o = req_phase ? (active_mask & ~done_q) : '0;
        granted    = tcdm_req_o & tcdm_gnt_i;
        in_gnt_o   = req_phase && ((active_mask & ~(done_q | granted)) == '0);

        resp       = (state_q == WAIT) ? (tcdm_r_valid_i & exp_q) : '0;
        unexpected = tcdm_r_valid_i & ~resp;
        last_resp  = (state_q == WAIT) && (exp_q != '0) && ((exp_q & ~resp) == '0);
        in_r_valid_o = last_resp;

        in_r_data_o = '0;
        for (int i = 0; i < int'(MP); i++) begin
            in_r_data_o[32*i +: 32] = resp[i] ? tcdm_r_data_i[i] : buf_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            done_q      <= '0;
            exp_q       <= '0;
            buf_q       <= '0;
            stall_cnt_o <= '0;
            err_o       <= 1'b0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            done_q      <= '0;
            exp_q       <= '0;
            buf_q       <= '0;
            stall_cnt_o <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ISSUE: begin
                    if (in_gnt_o) begin
                        done_q <= '0;
                        if (in_wen_i) begin
                            state_q <= WAIT;
                            exp_q   <= active_mask;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        done_q <= done_q | granted;
                        if (|granted) begin
                            state_q <= ISSUE;
                        end
                    end
                end
                WAIT: begin
                    for (int i = 0; i < int'(MP); i++) begin
                        if (resp[i]) begin
                            buf_q[i] <= tcdm_r_data_i[i];
                        end
                    end
                    exp_q <= exp_q & ~resp;
                    if (last_resp) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (|unexpected) begin
                err_o <= 1'b1;
            end

            if (in_req_i && !in_gnt_o && stall_cnt_o != 32'hFFFF_FFFF) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rbe_tcdm_split.sv
// Scenario bench for rbe_tcdm_split with BW=288 (9 lanes); expected wide read
// data is queued when the read is granted and popped when in_r_valid_o fires.
module tb_rbe_tcdm_split;

    localparam int BW = 288;
    localparam int MP = BW / 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  clear;
    logic                  in_req;
    logic                  in_gnt;
    logic [31:0]           in_add;
    logic                  in_wen;
    logic [BW/8-1:0]       in_be;
    logic [BW-1:0]         in_data;
    logic                  in_r_valid;
    logic [BW-1:0]         in_r_data;
    logic [MP-1:0]         tcdm_req;
    logic [MP-1:0][31:0]   tcdm_add;
    logic [MP-1:0]         tcdm_wen;
    logic [MP-1:0][3:0]    tcdm_be;
    logic [MP-1:0][31:0]   tcdm_data;
    logic [MP-1:0]         tcdm_gnt;
    logic [MP-1:0]         tcdm_r_valid;
    logic [MP-1:0][31:0]   tcdm_r_data;
    logic [31:0]           stall_cnt;
    logic                  err;

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    rbe_tcdm_split #(.BW(BW), .SKIP_EMPTY_WR(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .in_req_i       (in_req),
        .in_gnt_o       (in_gnt),
        .in_add_i       (in_add),
        .in_wen_i       (in_wen),
        .in_be_i        (in_be),
        .in_data_i      (in_data),
        .in_r_valid_o   (in_r_valid),
        .in_r_data_o    (in_r_data),
        .tcdm_req_o     (tcdm_req),
        .tcdm_add_o     (tcdm_add),
        .tcdm_wen_o     (tcdm_wen),
        .tcdm_be_o      (tcdm_be),
        .tcdm_data_o    (tcdm_data),
        .tcdm_gnt_i     (tcdm_gnt),
        .tcdm_r_valid_i (tcdm_r_valid),
        .tcdm_r_data_i  (tcdm_r_data),
        .stall_cnt_o    (stall_cnt),
        .err_o          (err)
    );

    function automatic logic [BW-1:0] rand_wide();
        logic [BW-1:0] v;
        for (int i = 0; i < MP; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_req = 0; in_wen = 0; in_add = '0; in_be = '0; in_data = '0;
        tcdm_gnt = '0; tcdm_r_valid = '0; tcdm_r_data = '0; clear = 0;
    endtask

    task automatic do_clear();
        cyc(); idle_inputs(); clear = 1;
        cyc(); clear = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs();
        cyc(); #1;
        checks++; if (in_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %0b want 0", in_gnt); end
        checks++; if (in_r_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %0b want 0", in_r_valid); end
        checks++; if (tcdm_req !== '0) begin errors++; $display("FAIL rst_req: got %h want 0", tcdm_req); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err); end
        cyc(); rst_n = 1;
    endtask

    task automatic test_read_full();
        logic [BW-1:0] lanes = rand_wide();
        logic [BW-1:0] e;
        cyc(); in_req = 1; in_wen = 1; in_add = 32'h1000; in_be = '1; tcdm_gnt = '1; #1;
        checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL rdf_gnt: got %0b want 1", in_gnt); end
        checks++; if (tcdm_req !== 9'h1FF) begin errors++; $display("FAIL rdf_req: got %h want 1ff", tcdm_req); end
        checks++; if (tcdm_add[8] !== 32'h1020) begin errors++; $display("FAIL rdf_add8: got %h want 1020", tcdm_add[8]); end
        checks++; if (tcdm_wen !== 9'h1FF) begin errors++; $display("FAIL rdf_wen: got %h want 1ff", tcdm_wen); end
        exp_q.push_back(lanes);
        cyc(); in_req = 0; tcdm_gnt = '0; tcdm_r_valid = '1; tcdm_r_data = lanes; #1;
        checks++; if (in_r_valid !== 1'b1) begin errors++; $display("FAIL rdf_rvalid: got %0b want 1", in_r_valid); end
        e = exp_q.pop_front();
        checks++; if (in_r_data !== e) begin errors++; $display("FAIL rdf_rdata: got %h want %h", in_r_data, e); end
        cyc(); tcdm_r_valid = '0; #1;
        checks++; if (in_r_valid !== 1'b0) begin errors++; $display("FAIL rdf_rvalid_drop: got %0b want 0", in_r_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rdf_err: got %0b want 0", err); end
    endtask

    task automatic test_read_late();
        logic [BW-1:0] lanes = rand_wide();
        logic [BW-1:0] e;
        cyc(); in_req = 1; in_wen = 1; in_add = 32'h4000; in_be = '1; tcdm_gnt = 9'h1F7; #1;
        checks++; if (in_gnt !== 1'b0) begin errors++; $display("FAIL rdl_gnt0: got %0b want 0", in_gnt); end
        checks++; if (tcdm_req !== 9'h1FF) begin errors++; $display("FAIL rdl_req0: got %h want 1ff", tcdm_req); end
        cyc(); tcdm_gnt = '0; #1;
        checks++; if (tcdm_req !== 9'h008) begin errors++; $display("FAIL rdl_req1: got %h want 008", tcdm_req); end
        checks++; if (in_gnt !== 1'b0) begin errors++; $display("FAIL rdl_gnt1: got %0b want 0", in_gnt); end
        cyc(); tcdm_gnt = 9'h008; #1;
        checks++; if (tcdm_req !== 9'h008) begin errors++; $display("FAIL rdl_req2: got %h want 008", tcdm_req); end
        checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL rdl_gnt2: got %0b want 1", in_gnt); end
        exp_q.push_back(lanes);
        cyc(); in_req = 0; tcdm_gnt = '0; tcdm_r_valid = 9'h1DF; tcdm_r_data = lanes; #1;
        checks++; if (in_r_valid !== 1'b0) begin errors++; $display("FAIL rdl_early_rvalid: got %0b want 0", in_r_valid); end
        // A new request during WAIT must be neither granted nor forwarded.
        cyc(); tcdm_r_valid = '0; in_req = 1; in_wen = 0; tcdm_gnt = '1; #1;
        checks++; if (in_gnt !== 1'b0) begin errors++; $display("FAIL rdl_wait_gnt: got %0b want 0", in_gnt); end
        checks++; if (tcdm_req !== '0) begin errors++; $display("FAIL rdl_wait_req: got %h want 0", tcdm_req); end
        cyc(); in_req = 0; tcdm_gnt = '0; #1;
        checks++; if (in_r_valid !== 1'b0) begin errors++; $display("FAIL rdl_wait_rvalid: got %0b want 0", in_r_valid); end
        cyc(); tcdm_r_valid = 9'h020; tcdm_r_data = ~lanes;
        tcdm_r_data[5] = lanes[32*5 +: 32]; #1;
        checks++; if (in_r_valid !== 1'b1) begin errors++; $display("FAIL rdl_rvalid: got %0b want 1", in_r_valid); end
        e = exp_q.pop_front();
        checks++; if (in_r_data !== e) begin errors++; $display("FAIL rdl_rdata: got %h want %h", in_r_data, e); end
        cyc(); tcdm_r_valid = '0; #1;
        checks++; if (in_r_valid !== 1'b0) begin errors++; $display("FAIL rdl_single: got %0b want 0", in_r_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rdl_err: got %0b want 0", err); end
    endtask

    task automatic test_write_sparse();
        logic [BW-1:0] d = rand_wide();
        cyc(); in_req = 1; in_wen = 0; in_add = 32'h2000; in_data = d; in_be = '0;
        in_be[3:0] = 4'b0011; in_be[31:28] = 4'b1000; tcdm_gnt = '1; #1;
        checks++; if (tcdm_req !== 9'h081) begin errors++; $display("FAIL wr_req: got %h want 081", tcdm_req); end
        checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %0b want 1", in_gnt); end
        checks++; if (tcdm_data[7] !== d[255:224]) begin errors++; $display("FAIL wr_data7: got %h want %h", tcdm_data[7], d[255:224]); end
        checks++; if (tcdm_add[7] !== 32'h201C) begin errors++; $display("FAIL wr_add7: got %h want 201c", tcdm_add[7]); end
        checks++; if (tcdm_be[7] !== 4'b1000) begin errors++; $display("FAIL wr_be7: got %h want 8", tcdm_be[7]); end
        checks++; if (tcdm_wen !== '0) begin errors++; $display("FAIL wr_wen: got %h want 0", tcdm_wen); end
        cyc(); in_be = '0; #1;
        checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL wr_empty_gnt: got %0b want 1", in_gnt); end
        checks++; if (tcdm_req !== '0) begin errors++; $display("FAIL wr_empty_req: got %h want 0", tcdm_req); end
        cyc(); in_be[3:0] = 4'b0011; in_be[31:28] = 4'b1000; tcdm_gnt = 9'h001; #1;
        checks++; if (in_gnt !== 1'b0) begin errors++; $display("FAIL wr_part_gnt: got %0b want 0", in_gnt); end
        cyc(); tcdm_gnt = '1; #1;
        checks++; if (tcdm_req !== 9'h080) begin errors++; $display("FAIL wr_part_req: got %h want 080", tcdm_req); end
        checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL wr_part_gnt2: got %0b want 1", in_gnt); end
        // The write returns to IDLE, so the next request sees all active lanes again.
        cyc(); #1;
        checks++; if (tcdm_req !== 9'h081) begin errors++; $display("FAIL wr_back_req: got %h want 081", tcdm_req); end
        cyc(); idle_inputs();
    endtask

    task automatic test_err();
        cyc(); tcdm_r_valid = 9'h004; tcdm_r_data = '1;
        cyc(); tcdm_r_valid = '0; #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b want 1", err); end
        cyc(); cyc(); cyc(); #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", err); end
        do_clear(); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", err); end
    endtask

    task automatic test_stall();
        do_clear();
        cyc(); in_req = 1; in_wen = 1; in_add = 32'h3000; in_be = '1; tcdm_gnt = '0;
        for (int k = 0; k < 9; k++) cyc();
        cyc(); in_req = 0; #1;
        checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL stall_cnt: got %0d want 10", stall_cnt); end
        cyc(); #1;
        checks++; if (stall_cnt !== 32'd10) begin errors++; $display("FAIL stall_hold: got %0d want 10", stall_cnt); end
        do_clear(); #1;
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_clear: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_reset_wait();
        logic [BW-1:0] lanes = rand_wide();
        cyc(); in_req = 1; in_wen = 1; in_add = 32'h5000; in_be = '1; tcdm_gnt = '1; #1;
        checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL rw_gnt: got %0b want 1", in_gnt); end
        cyc(); in_req = 0; tcdm_gnt = '0; rst_n = 0; #1;
        checks++; if (in_r_valid !== 1'b0) begin errors++; $display("FAIL rw_rvalid_rst: got %0b want 0", in_r_valid); end
        cyc(); rst_n = 1; tcdm_r_valid = '1; tcdm_r_data = lanes; #1;
        checks++; if (in_r_valid !== 1'b0) begin errors++; $display("FAIL rw_rvalid_late: got %0b want 0", in_r_valid); end
        cyc(); tcdm_r_valid = '0; #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rw_err: got %0b want 1", err); end
        cyc(); in_req = 1; in_wen = 0; in_be = '1; tcdm_gnt = '1; #1;
        checks++; if (in_gnt !== 1'b1) begin errors++; $display("FAIL rw_idle_gnt: got %0b want 1", in_gnt); end
        cyc(); idle_inputs(); #1;
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rw_queue: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_read_full();
        test_read_late();
        test_write_sparse();
        test_err();
        test_stall();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
